rf_wb_arbiter: RTL

Write-back arbiter for the 32-bit register file. It queues register writes from two producers (ALU write-back and load write-back) and grants the file's single write port to one queued write per cycle, using round-robin. Its registered outputs drive the register file's write enable, write address and write data directly. It also reports read-after-write hazards for the two register-file read addresses so decode can stall.

---
 rtl/rf_wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two per-requester FIFOs share the register file's single
// write port round-robin, with read-after-write hazard flags for decode.
module rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [3:0]  m_addr,
    input  logic [31:0] m_data,
    output logic        we,
    output logic [3:0]  wa,
    output logic [31:0] wd,
    input  logic [3:0]  in1,
    input  logic [3:0]  in2,
    output logic        hz1,
    output logic        hz2,
    output logic        idle
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Index 0 is the ALU requester, index 1 the load requester.
    logic [3:0]       q_addr  [2][DEPTH];
    logic [31:0]      q_data  [2][DEPTH];
    logic [DEPTH-1:0] q_vld   [2];
    logic [DEPTH-1:0] vld_nxt [2];
    logic [AW-1:0]    wr_ptr  [2];
    logic [AW-1:0]    rd_ptr  [2];
    logic [CW-1:0]    cnt     [2];
    logic [3:0]       in_addr [2];
    logic [31:0]      in_data [2];
    logic [1:0]       push, pop, nonempty, ready;
    logic             gnt_valid, gnt, last_grant;

    assign in_addr[0] = a_addr;
    assign in_addr[1] = m_addr;
    assign in_data[0] = a_data;
    assign in_data[1] = m_data;

    // Handshake: a write is taken on a posedge where valid && ready; ready depends
    // only on the registered count (no full-FIFO bypass) and is low during reset.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            nonempty[r] = (cnt[r] != '0);
            ready[r]    = !reset && (cnt[r] < CW'(DEPTH));
        end
    end

    assign push    = {m_valid, a_valid} & ready;
    assign a_ready = ready[0];
    assign m_ready = ready[1];

    // On a tie, the requester that did not win last time goes first.
    always_comb begin
        gnt_valid = |nonempty;
        gnt       = 1'b0;
        pop       = '0;
        if (&nonempty)
            gnt = ~last_grant;
        else if (nonempty[1])
            gnt = 1'b1;
        if (gnt_valid)
            pop[gnt] = 1'b1;
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            vld_nxt[r] = q_vld[r];
            if (pop[r])
                vld_nxt[r][rd_ptr[r]] = 1'b0;
            if (push[r])
                vld_nxt[r][wr_ptr[r]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                cnt[r]    <= '0;
                q_vld[r]  <= '0;
            end
            last_grant <= 1'b1;
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r])
                    wr_ptr[r] <= wr_ptr[r] + 1'b1;
                if (pop[r])
                    rd_ptr[r] <= rd_ptr[r] + 1'b1;
                cnt[r]   <= cnt[r] + CW'(push[r]) - CW'(pop[r]);
                q_vld[r] <= vld_nxt[r];
            end
            if (gnt_valid) begin
                last_grant <= gnt;
                we         <= 1'b1;
                wa         <= q_addr[gnt][rd_ptr[gnt]];
                wd         <= q_data[gnt][rd_ptr[gnt]];
            end else begin
                we <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by q_vld.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                q_addr[r][wr_ptr[r]] <= in_addr[r];
                q_data[r][wr_ptr[r]] <= in_data[r];
            end
        end
    end

    // Hazards look only at registered state: queued entries and the write in flight.
    always_comb begin
        hz1 = we && (wa == in1);
        hz2 = we && (wa == in2);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_vld[r][i] && (q_addr[r][i] == in1))
                    hz1 = 1'b1;
                if (q_vld[r][i] && (q_addr[r][i] == in2))
                    hz2 = 1'b1;
            end
        end
    end

    assign idle = (cnt[0] == '0) && (cnt[1] == '0) && !we;

endmodule
